// File: rtl/out_port_serializer.sv
// Watches four 8-bit processor output ports, queues each value change as a
// tagged entry, and transmits each entry as one UART-style serial frame.
module out_port_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic [7:0]                    OutExtWorld1,
  input  logic [7:0]                    OutExtWorld2,
  input  logic [7:0]                    OutExtWorld3,
  input  logic [7:0]                    OutExtWorld4,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          coalesced
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

  logic [7:0]    port_in [4];
  logic [7:0]    prev    [4];
  logic [7:0]    pval    [4];
  logic [3:0]    pend;
  logic [1:0]    sel;
  logic          found;
  logic          push;
  logic          pop;
  logic          empty;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    head;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          tx_q, tx_d;

  assign port_in[0] = OutExtWorld1;
  assign port_in[1] = OutExtWorld2;
  assign port_in[2] = OutExtWorld3;
  assign port_in[3] = OutExtWorld4;

  assign empty     = (fifo_count == '0);
  assign head      = mem[rd_ptr];
  assign tx_serial = tx_q;
  assign tx_busy   = (state_q != IDLE);

  // Lowest-index pending port wins; a full FIFO blocks even when a pop coincides.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && pend[i]) begin
        sel   = 2'(i);
        found = 1'b1;
      end
    end
    push = found && (fifo_count < FULL_COUNT);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      pend      <= '0;
      coalesced <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        prev[k] <= '0;
        pval[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (port_in[k] != prev[k]) begin
          prev[k] <= port_in[k];
          pval[k] <= port_in[k];
          pend[k] <= 1'b1;
          if (pend[k] && !(push && sel == 2'(k)))
            coalesced <= 1'b1;
        end else if (push && sel == 2'(k)) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  // Entries are stored {data, index} so that bit i is the i-th bit on the wire.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {pval[sel], sel};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the next state, so the line itself is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          frame_d = head;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = BITS;
          tx_d    = frame_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = frame_q[bit_d];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            frame_d = head;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_out_port_serializer.sv
// Directed bench for out_port_serializer: decodes frames off the serial line
// and compares them against hand-computed port/value sequences.
module tb_out_port_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] p1, p2, p3, p4;
  logic       tx_serial;
  logic       tx_busy;
  logic [3:0] fifo_count;
  logic       coalesced;

  int total = 0;
  int bad   = 0;

  out_port_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .OutExtWorld1 (p1),
    .OutExtWorld2 (p2),
    .OutExtWorld3 (p3),
    .OutExtWorld4 (p4),
    .tx_serial    (tx_serial),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count),
    .coalesced    (coalesced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; waited = negedges until the start bit is seen.
  task automatic rx_frame(output logic [1:0] idx, output logic [7:0] data,
                          output logic stop, output int waited, output logic timeout);
    logic [11:0] bits;
    waited  = 0;
    timeout = 1'b0;
    bits    = '0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_serial !== 1'b0 && waited < 600);
    if (tx_serial !== 1'b0) begin
      timeout = 1'b1;
    end else begin
      for (int c = 1; c <= 45; c++) begin
        @(negedge clk);
        if (c % 4 == 1) bits[c/4] = tx_serial;
      end
    end
    idx  = bits[2:1];
    data = bits[10:3];
    stop = bits[11];
  endtask

  initial begin
    logic [11:0] seq;
    logic [1:0]  idx;
    logic [7:0]  data;
    logic        stop;
    logic        tmo;
    int          waited;
    int          viol;
    int          bc;
    int          peak;

    Reset = 1'b1;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_serial, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_coal", coalesced, 0);
    Reset = 1'b0;

    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 4'd0) viol++;
    end
    check("idle100_viol", viol, 0);

    // Single update 0xAA on port index 0
    p1 = 8'hAA;
    @(negedge clk);
    check("aa_e0_tx", tx_serial, 1);
    @(negedge clk);
    check("aa_e1_count", fifo_count, 1);
    check("aa_e1_tx", tx_serial, 1);
    @(negedge clk);
    check("aa_e2_busy", tx_busy, 1);
    check("aa_e2_count", fifo_count, 0);
    seq = 12'b1101_0101_0000;
    bc  = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_busy === 1'b1) bc++;
      if (c % 4 == 1 && c < 48) check($sformatf("aa_bit%0d", c/4), tx_serial, seq[c/4]);
      if (c == 48) begin
        check("aa_after_tx", tx_serial, 1);
        check("aa_after_busy", tx_busy, 0);
      end
      @(negedge clk);
    end
    check("aa_busy_cycles", bc, 48);

    // Two ports change together: back-to-back frames, lower index first
    p2 = 8'hCC;
    p4 = 8'h0F;
    peak = 0;
    fork
      begin
        rx_frame(idx, data, stop, waited, tmo);
        check("two_f1_tmo", tmo, 0);
        check("two_f1_idx", idx, 1);
        check("two_f1_data", data, 8'hCC);
        check("two_f1_stop", stop, 1);
        rx_frame(idx, data, stop, waited, tmo);
        check("two_f2_tmo", tmo, 0);
        check("two_f2_gap", waited, 3);
        check("two_f2_idx", idx, 3);
        check("two_f2_data", data, 8'h0F);
      end
      begin
        for (int i = 0; i < 120; i++) begin
          @(negedge clk);
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
      end
    join
    check("two_peak", peak, 1);
    check("two_coal", coalesced, 0);

    // Port 0 changes every cycle: FIFO fills, later values coalesce
    peak = 0;
    fork
      begin
        for (int v = 1; v <= 16; v++) begin
          p1 = 8'(v);
          @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 560; i++) begin
          @(negedge clk);
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
      end
      begin
        for (int f = 0; f < 10; f++) begin
          rx_frame(idx, data, stop, waited, tmo);
          check($sformatf("burst_f%0d_tmo", f), tmo, 0);
          check($sformatf("burst_f%0d_idx", f), idx, 0);
          check($sformatf("burst_f%0d_data", f), data, (f < 9) ? f + 1 : 32'h10);
        end
      end
    join
    check("burst_peak", peak, 8);
    check("burst_coal", coalesced, 1);

    // Reset in the middle of a frame with three entries queued
    p1 = 8'h44; p2 = 8'h11; p3 = 8'h22; p4 = 8'h33;
    repeat (5) @(negedge clk);
    check("mid_queued", fifo_count, 3);
    repeat (18) @(negedge clk);
    check("mid_busy_pre", tx_busy, 1);
    Reset = 1'b1;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;
    @(negedge clk);
    check("mid_rst_tx", tx_serial, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_coal", coalesced, 0);
    Reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 4'd0) viol++;
    end
    check("mid_quiet_viol", viol, 0);

    // Port index 2 pulses 0x5A then returns to 0x00 during the first frame
    p3 = 8'h5A;
    fork
      begin
        repeat (5) @(negedge clk);
        p3 = 8'h00;
      end
      begin
        rx_frame(idx, data, stop, waited, tmo);
        check("pulse_f1_tmo", tmo, 0);
        check("pulse_f1_idx", idx, 2);
        check("pulse_f1_data", data, 8'h5A);
        rx_frame(idx, data, stop, waited, tmo);
        check("pulse_f2_tmo", tmo, 0);
        check("pulse_f2_gap", waited, 3);
        check("pulse_f2_idx", idx, 2);
        check("pulse_f2_data", data, 8'h00);
      end
    join
    repeat (10) @(negedge clk);
    check("pulse_end_busy", tx_busy, 0);
    check("pulse_end_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
